// File: rtl/dac_wave_seq.sv
// ============================================================================
//  Module   : dac_wave_seq
//  Purpose  : Host-load / timed-playback sequencer for the DAC waveform BRAM.
//             Define DAC_SEQ_BRAM_OREG_EN when the BRAM output register is used.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dac_wave_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ada,
    output logic [DATA_W-1:0] din,
    output logic              cea,
    output logic              reseta,
    output logic [ADDR_W-1:0] adb,
    output logic              ceb,
    output logic              resetb,
    output logic              oce,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid
);

`ifdef DAC_SEQ_BRAM_OREG_EN
    localparam int   LAT     = 2;
    localparam logic c_OCE   = 1'b1;
`else
    localparam int   LAT     = 1;
    localparam logic c_OCE   = 1'b0;
`endif
    localparam logic [DIV_W-1:0]  c_DIV_ONE  = DIV_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_cnt;
    logic                r_oneshot;
    logic [LAT-1:0]      r_tag;
    logic [DATA_W-1:0]   r_dac_data;
    logic                r_done;

    logic                w_idle;
    logic                w_wr_ready;
    logic                w_wr_fire;
    logic                w_tick;
    logic                w_last;
    logic                w_rd_issue;
    logic [LAT:0]        w_tag_chain;
    logic                w_pending;
    logic                w_dac_valid;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_wr_ready  = w_idle & sys_rst_n;
    assign w_wr_fire   = wr_valid & w_wr_ready;
    assign w_tick      = (r_cnt == r_div);
    assign w_last      = (r_rd_addr == r_len);
    // Read strobe is combinational so the first read lands in the first PLAY cycle
    // and a stop in the same cycle suppresses it.
    assign w_rd_issue  = sys_rst_n & (r_state == ST_PLAY) & w_tick & ~stop;
    assign w_tag_chain = {r_tag, w_rd_issue};
    assign w_pending   = |w_tag_chain[LAT-1:0];
    assign w_dac_valid = w_tag_chain[LAT] & sys_rst_n;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_rd_addr  <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_oneshot  <= 1'b0;
            r_tag      <= '0;
            r_dac_data <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_tag  <= w_tag_chain[LAT-1:0];
            if (w_dac_valid) begin
                r_dac_data <= dout;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_len     <= cfg_len;
                        r_div     <= cfg_div;
                        r_oneshot <= cfg_oneshot;
                        r_rd_addr <= '0;
                        r_cnt     <= cfg_div;
                        r_state   <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        r_state <= ST_DRAIN;
                    end else if (w_tick) begin
                        r_cnt <= '0;
                        if (w_last) begin
                            r_rd_addr <= '0;
                            if (r_oneshot) begin
                                r_state <= ST_DRAIN;
                            end
                        end else begin
                            r_rd_addr <= r_rd_addr + c_ADDR_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_DIV_ONE;
                    end
                end
                ST_DRAIN: begin
                    // Leave once only the final tag (if any) is exiting this cycle.
                    if (!w_pending) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_ready  = w_wr_ready;
    assign cea       = w_wr_fire;
    assign ada       = w_wr_fire ? wr_addr : '0;
    assign din       = w_wr_fire ? wr_data : '0;
    assign reseta    = ~sys_rst_n;
    assign resetb    = ~sys_rst_n;
    assign ceb       = w_rd_issue;
    assign adb       = w_rd_issue ? r_rd_addr : '0;
    assign oce       = c_OCE;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done & sys_rst_n;
    assign dac_valid = w_dac_valid;
    assign dac_data  = w_dac_valid ? dout : r_dac_data;

endmodule

`default_nettype wire
